// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit_if
//  Purpose  : Request/result bundle between the pipeline and mul_div_unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opA, opB, mthi, mtlo,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, opA, opB, mthi, mtlo,
        output busy, done, dbz, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mul_div_unit_if.slave    bus
);
    localparam logic [4:0] c_last_iter = 5'd31;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [4:0]         r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz_pend;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_load;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_work_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_load  = (r_state == IDLE) && bus.start;
    assign w_last  = (r_state == RUN) && (r_cnt == c_last_iter);
    assign w_a_neg = bus.op[0] & bus.opA[WIDTH-1];
    assign w_b_neg = bus.op[0] & bus.opB[WIDTH-1];
    assign w_mag_a = w_a_neg ? -bus.opA : bus.opA;
    assign w_mag_b = w_b_neg ? -bus.opB : bus.opB;

    // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
    assign w_sum  = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_work[0] ? {1'b0, r_mag_b} : '0);
    // Divide: shift the {rem, quo} pair left and keep the trial subtraction if it fits.
    assign w_sh   = {r_work[2*WIDTH-1:WIDTH], r_work[WIDTH-1]};
    assign w_ge   = (w_sh >= {1'b0, r_mag_b});
    assign w_diff = w_sh[WIDTH-1:0] - r_mag_b;

    assign w_work_next = r_is_div
        ? {(w_ge ? w_diff : w_sh[WIDTH-1:0]), r_work[WIDTH-2:0], w_ge}
        : {w_sum, r_work[WIDTH-1:1]};

    assign w_prod = r_neg_q ? -w_work_next : w_work_next;
    assign w_quo  = r_neg_q ? -w_work_next[WIDTH-1:0] : w_work_next[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -w_work_next[2*WIDTH-1:WIDTH] : w_work_next[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = RUN;
            RUN:     if (r_cnt == c_last_iter) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_opa      <= '0;
            r_mag_b    <= '0;
            r_work     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_cnt      <= '0;
                r_is_div   <= bus.op[1];
                r_neg_q    <= w_a_neg ^ w_b_neg;
                r_neg_r    <= w_a_neg;
                r_dbz_pend <= bus.op[1] && (bus.opB == '0);
                r_opa      <= bus.opA;
                r_mag_b    <= w_mag_b;
                r_work     <= {{WIDTH{1'b0}}, w_mag_a};
            end else if (r_state == RUN) begin
                r_cnt  <= r_cnt + 5'd1;
                r_work <= w_work_next;
            end

            if (w_last) begin
                r_dbz <= r_dbz_pend;
                if (r_dbz_pend) begin
                    r_hi <= r_opa;
                    r_lo <= '1;
                end else if (r_is_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end else if ((r_state == IDLE) && !bus.start) begin
                if (bus.mthi) r_hi <= bus.opA;
                if (bus.mtlo) r_lo <= bus.opA;
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
    assign bus.dbz  = r_dbz;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port opA  input  32  multiplicand or dividend, the same operand bus that feeds the ALU.
REQ-007 SHALL have port opB  input  32  multiplier or divisor, the same operand bus that feeds the ALU.
REQ-008 SHALL have port mthi  input  1  load hi from opA.
REQ-009 SHALL have port mtlo  input  1  load lo from opA.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when hi/lo are updated with a result.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag for the last completed operation.
REQ-013 SHALL have port hi  output  32  HI register: product upper half or remainder.
REQ-014 SHALL have port lo  output  32  LO register: product lower half or quotient.

Function
REQ-015 SHALL implement FSM states IDLE and RUN, with a 5-bit iteration counter.
REQ-016 SHALL, in IDLE with start=1 at edge E0, latch op, latch operand magnitudes (two's-complement abs for signed ops), latch the sign rules, clear the counter and enter RUN.
REQ-017 SHALL perform one iteration per RUN edge: shift-add for multiply, restoring shift-subtract for divide, on 64-bit working registers separate from hi/lo.
REQ-018 SHALL, on the 32nd RUN edge (E32), write the sign-corrected result to hi/lo, set done=1, update dbz and return to IDLE; latency is fixed at 32 cycles from start to done for every op.
REQ-019 SHALL drive busy = (state==RUN), i.e. high from after E0 until E32.
REQ-020 SHALL drive done high for exactly the cycle after E32 and low otherwise.
REQ-021 SHALL hold hi/lo at their previous values throughout RUN.
REQ-022 SHALL compute signed MULT as the 64-bit two's-complement product: magnitude product, negated if sign(opA) XOR sign(opB).
REQ-023 SHALL compute signed DIV with a truncating quotient, negated if sign(opA) XOR sign(opB), and a remainder carrying the sign of opA.
REQ-024 SHALL return lo=0x80000000 and hi=0 for DIV 0x80000000 / 0xFFFFFFFF (natural wrap, no flag).
REQ-025 SHALL, on a divide by zero (opB=0 with op=1x), return hi=opA unchanged, lo=0xFFFFFFFF and dbz=1 at the normal E32 completion; multiply completions clear dbz to 0.
REQ-026 SHALL ignore start while in RUN; operands on the bus after E0 have no effect.
REQ-027 SHALL accept start in the done cycle, since the state is then IDLE.
REQ-028 SHALL load hi from opA on mthi, and lo from opA on mtlo, at the edge in IDLE; both may occur in the same cycle.
REQ-029 SHALL ignore mthi/mtlo in RUN, and when start=1 in the same IDLE cycle (start has priority).

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-RUN, asynchronously force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, dbz=0 and clear the working registers.
REQ-031 SHALL, after rst_n deasserts, accept start on the first rising edge.

Verification
REQ-032 SHALL cover: MULTU opA=0xFFFFFFFF, opB=0xFFFFFFFF -> done exactly 32 edges after start, hi=0xFFFFFFFE, lo=0x00000001, busy high 32 cycles.
REQ-033 SHALL cover: MULT opA=0xFFFFFFFD (-3), opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV opA=0xFFFFFFF9 (-7), opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 SHALL cover: DIVU opA=5, opB=0 -> hi=0x00000005, lo=0xFFFFFFFF, dbz=1; a following MULTU 2*3 -> lo=6, hi=0, dbz=0.
REQ-035 SHALL cover: start MULTU 2*3, pulse start with opA=9 and mthi=1 at RUN cycle 5 -> both ignored, result lo=6, hi=0 at E32.
REQ-036 SHALL cover: rst_n low at RUN cycle 10 -> busy, done, hi and lo are 0 immediately; a new DIVU 100/7 -> lo=14, hi=2 after 32 cycles.
REQ-037 SHALL cover: start asserted in the done cycle -> accepted, busy rises the next cycle, done low the next cycle.
